// File: rtl/rom_seq_ctrl_pkg.sv
// Shared definitions for the ROM sequencing controller.
//   - Opcode encodings of the 2-bit instruction set.
//   - Controller state encoding.
package rom_seq_ctrl_pkg;

    localparam logic [1:0] OP_INC = 2'b00;  // {ovf,acc} <= acc + 1
    localparam logic [1:0] OP_JNO = 2'b01;  // jump to fixed target when ovf == 0
    localparam logic [1:0] OP_HLT = 2'b10;  // stop in HALT
    localparam logic [1:0] OP_RSV = 2'b11;  // reserved: NOP that sets illegal

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_seq_ctrl.sv
// Fetch/execute controller for the 4-entry, 2-bit instruction ROM.
// Every instruction takes two cycles: FETCH latches the combinational ROM
// output into ir, EXEC commits its effect on pc/acc/ovf/illegal.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (priority over start)
//   start      one-cycle pulse, honoured only in IDLE or HALT
//   instr      opcode returned by the ROM for {sel2,sel1}
//   sel1/sel2  ROM address bits 0/1 (always equal pc)
//   acc        accumulator
//   ovf        carry-out of the most recent INC
//   busy       high in FETCH or EXEC
//   halted     high in HALT
//   illegal    sticky: reserved opcode was executed
module rom_seq_ctrl
    import rom_seq_ctrl_pkg::*;
#(
    parameter int         ACC_W      = 4,
    parameter logic [1:0] JNO_TARGET = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       instr,
    output logic             sel1,
    output logic             sel2,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             busy,
    output logic             halted,
    output logic             illegal
);

    state_t           state_reg, state_next;
    logic [1:0]       pc_reg, pc_next;
    logic [1:0]       ir_reg, ir_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             ovf_reg, ovf_next;
    logic             illegal_reg, illegal_next;

    logic [ACC_W:0]   inc_sum;
    logic [1:0]       pc_inc;

    // One extra bit so the carry of an INC lands directly in ovf.
    assign inc_sum = {1'b0, acc_reg} + (ACC_W+1)'(1);
    assign pc_inc  = pc_reg + 2'd1;   // wraps 3 -> 0

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= 2'b00;
            ir_reg      <= 2'b00;
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            acc_reg     <= acc_next;
            ovf_reg     <= ovf_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        acc_next     = acc_reg;
        ovf_next     = ovf_reg;
        illegal_next = illegal_reg;

        case (state_reg)
            // IDLE and HALT both restart the program on start.
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_next      = 2'b00;
                    acc_next     = '0;
                    ovf_next     = 1'b0;
                    illegal_next = 1'b0;
                    state_next   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_next    = instr;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
                case (ir_reg)
                    OP_INC: begin
                        {ovf_next, acc_next} = inc_sum;
                        pc_next = pc_inc;
                    end
                    OP_JNO: begin
                        pc_next = ovf_reg ? pc_inc : JNO_TARGET;
                    end
                    OP_HLT: begin
                        state_next = ST_HALT;   // pc holds on the HLT
                    end
                    default: begin              // OP_RSV
                        illegal_next = 1'b1;
                        pc_next      = pc_inc;
                    end
                endcase
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign sel1    = pc_reg[0];
    assign sel2    = pc_reg[1];
    assign acc     = acc_reg;
    assign ovf     = ovf_reg;
    assign illegal = illegal_reg;
    assign busy    = (state_reg == ST_FETCH) || (state_reg == ST_EXEC);
    assign halted  = (state_reg == ST_HALT);

endmodule
